// File: rtl/dmux8way_buffered_pkg.sv
// rtl/dmux8way_buffered_pkg.sv - shared lane constants, lane state type and slice helper
package dmux8way_buffered_pkg;
   localparam int DMUX_WAYS  = 8;
   localparam int DMUX_SEL_W = 3;
   localparam int DMUX_CNT_W = 8;

   typedef enum logic {
      LANE_EMPTY = 1'b0,
      LANE_FULL  = 1'b1
   } lane_state_e;

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction
endpackage

// File: rtl/dmux_lane_reg.sv
// rtl/dmux_lane_reg.sv - one-entry valid/ready holding register for a single output lane
// Optional per-lane transfer counter under DMUX_STATS_EN.
module dmux_lane_reg
   import dmux8way_buffered_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_load,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_ready,
`ifdef DMUX_STATS_EN
   input  logic                  i_clear,
   output logic [DMUX_CNT_W-1:0] o_count,
`endif
   output logic                  o_valid,
   output logic [WIDTH-1:0]      o_data
);
   lane_state_e      r_state;
   logic [WIDTH-1:0] r_data;
   logic             w_drain;

   assign w_drain = (r_state == LANE_FULL) && i_ready;
   assign o_valid = (r_state == LANE_FULL);
   assign o_data  = r_data;

   // A load in the drain cycle keeps the lane FULL, giving one word per cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= LANE_EMPTY;
         r_data  <= '0;
      end else if (i_load) begin
         r_state <= LANE_FULL;
         r_data  <= i_data;
      end else if (w_drain) begin
         r_state <= LANE_EMPTY;
      end
   end

`ifdef DMUX_STATS_EN
   logic [DMUX_CNT_W-1:0] r_count;

   assign o_count = r_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (w_drain) begin
         r_count <= r_count + 1'b1;
      end
   end
`endif
endmodule

// File: rtl/dmux8way_buffered.sv
// rtl/dmux8way_buffered.sv - registered 1-to-8 valid/ready demultiplexer with per-lane holding registers
// Optional DMUX_STATS_EN adds per-lane output transfer counters and a synchronous clear.
module dmux8way_buffered
   import dmux8way_buffered_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [DMUX_SEL_W-1:0]      in_sel,
   output logic [DMUX_WAYS-1:0]       out_valid,
   input  logic [DMUX_WAYS-1:0]       out_ready,
   output logic [DMUX_WAYS*WIDTH-1:0] out_data,
`ifdef DMUX_STATS_EN
   input  logic                       stats_clear,
   output logic [DMUX_WAYS*DMUX_CNT_W-1:0] lane_count,
`endif
   output logic                       busy
);
   logic [DMUX_WAYS-1:0] w_valid;
   logic                 w_accept;

   // Only the addressed lane gates acceptance; other lanes never block the producer.
   assign in_ready  = !w_valid[in_sel] || out_ready[in_sel];
   assign w_accept  = in_valid && in_ready;
   assign out_valid = w_valid;
   assign busy      = |w_valid;

   for (genvar g = 0; g < DMUX_WAYS; g++) begin : g_lane
      localparam int LSB = lane_lsb(g, WIDTH);
      logic w_load;

      assign w_load = w_accept && (in_sel == DMUX_SEL_W'(g));

      dmux_lane_reg #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clock   (clock),
         .reset_n (reset_n),
         .i_load  (w_load),
         .i_data  (in_data),
         .i_ready (out_ready[g]),
`ifdef DMUX_STATS_EN
         .i_clear (stats_clear),
         .o_count (lane_count[g*DMUX_CNT_W +: DMUX_CNT_W]),
`endif
         .o_valid (w_valid[g]),
         .o_data  (out_data[LSB +: WIDTH])
      );
   end
endmodule

// File: tb/tb_dmux8way_buffered.sv
// tb/tb_dmux8way_buffered.sv - randomized and directed bench for dmux8way_buffered against an array model
module tb_dmux8way_buffered;
   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [2:0]    in_sel;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;
   logic [8*W-1:0] out_data;
   logic          busy;
`ifdef DMUX_STATS_EN
   logic          stats_clear;
   logic [63:0]   lane_count;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0]   mv;
   logic [W-1:0] md [8];

   dmux8way_buffered #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
`ifdef DMUX_STATS_EN
      .stats_clear (stats_clear),
      .lane_count  (lane_count),
`endif
      .busy        (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*W-1:0] model_data();
      logic [8*W-1:0] v;
      for (int k = 0; k < 8; k++) v[k*W +: W] = md[k];
      return v;
   endfunction

   task automatic model_reset();
      mv = 8'h00;
      for (int k = 0; k < 8; k++) md[k] = '0;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".valid"}, 128'(out_valid), 128'(mv));
      check_eq({tag, ".data"},  128'(out_data),  128'(model_data()));
      check_eq({tag, ".busy"},  128'(busy),      128'(mv != 8'h00));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                        input logic [7:0] r, output logic acc);
      logic exp_rdy;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      #1;
      exp_rdy = !mv[s] || r[s];
      check_eq("in_ready", 128'(in_ready), 128'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clock);
      for (int k = 0; k < 8; k++) begin
         if (acc && s == 3'(k)) begin
            mv[k] = 1'b1;
            md[k] = d;
         end else if (mv[k] && r[k]) begin
            mv[k] = 1'b0;
         end
      end
      @(negedge clock);
      check_outputs("cycle");
   endtask

   initial begin
      logic       acc;
      logic       pv;
      logic [2:0] ps;
      logic [W-1:0] pd;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 3'd0;
      in_data   = '0;
      out_ready = 8'h00;
`ifdef DMUX_STATS_EN
      stats_clear = 1'b0;
`endif
      model_reset();
      repeat (3) @(negedge clock);
      check_eq("rst.valid", 128'(out_valid), 128'(8'h00));
      check_eq("rst.data",  128'(out_data),  128'(0));
      check_eq("rst.busy",  128'(busy),      128'(1'b0));
      reset_n = 1'b1;
      @(negedge clock);

      // Sweep every lane with a free-running consumer.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 3'(i), W'(i), 8'hFF, acc);
         check_eq("sweep.accept", 128'(acc), 128'(1'b1));
         check_eq("sweep.valid", 128'(out_valid), 128'(8'h01 << i));
         check_eq("sweep.data", 128'(out_data[i*W +: W]), 128'(i));
      end
      cycle(1'b0, 3'd0, '0, 8'hFF, acc);
      check_eq("sweep.empty", 128'(out_valid), 128'(8'h00));

      // Backpressure on lane 3.
      cycle(1'b1, 3'd3, 16'hBEEF, 8'h00, acc);
      check_eq("bp.first", 128'(acc), 128'(1'b1));
      repeat (2) begin
         cycle(1'b1, 3'd3, 16'hCAFE, 8'h00, acc);
         check_eq("bp.stall", 128'(acc), 128'(1'b0));
         check_eq("bp.hold", 128'(out_data[3*W +: W]), 128'(16'hBEEF));
      end
      cycle(1'b1, 3'd3, 16'hCAFE, 8'h08, acc);
      check_eq("bp.second", 128'(acc), 128'(1'b1));
      check_eq("bp.cafe", 128'(out_data[3*W +: W]), 128'(16'hCAFE));
      check_eq("bp.valid", 128'(out_valid), 128'(8'h08));
      cycle(1'b0, 3'd0, '0, 8'hFF, acc);

      // Same-cycle drain and reload on lane 4.
      cycle(1'b1, 3'd4, 16'h1111, 8'h00, acc);
      cycle(1'b1, 3'd4, 16'h2222, 8'h10, acc);
      check_eq("dl.accept", 128'(acc), 128'(1'b1));
      check_eq("dl.valid", 128'(out_valid), 128'(8'h10));
      check_eq("dl.data", 128'(out_data[4*W +: W]), 128'(16'h2222));
      cycle(1'b0, 3'd0, '0, 8'hFF, acc);

      // Stalled lane 6 must not block lane 1.
      cycle(1'b1, 3'd6, 16'h6666, 8'h00, acc);
      cycle(1'b1, 3'd1, 16'h0A0A, 8'h00, acc);
      check_eq("par.accept", 128'(acc), 128'(1'b1));
      check_eq("par.valid", 128'(out_valid), 128'(8'h42));
      cycle(1'b0, 3'd0, '0, 8'hFF, acc);

      // Asynchronous reset with lanes 2 and 5 full.
      cycle(1'b1, 3'd2, 16'h2020, 8'h00, acc);
      cycle(1'b1, 3'd5, 16'h5050, 8'h00, acc);
      check_eq("ar.pre", 128'(out_valid), 128'(8'h24));
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("ar.valid", 128'(out_valid), 128'(8'h00));
      check_eq("ar.busy", 128'(busy), 128'(1'b0));
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      check_outputs("ar.release");
      cycle(1'b0, 3'd2, '0, 8'h00, acc);
      check_eq("ar.nospur", 128'(out_valid), 128'(8'h00));

`ifdef DMUX_STATS_EN
      stats_clear = 1'b1;
      cycle(1'b0, 3'd0, '0, 8'h00, acc);
      stats_clear = 1'b0;
      check_eq("st.clear", 128'(lane_count), 128'(0));
      cycle(1'b1, 3'd7, 16'h7000, 8'h00, acc);
      for (int i = 0; i < 256; i++) cycle(1'b1, 3'd7, W'(i), 8'h80, acc);
      cycle(1'b0, 3'd0, '0, 8'h80, acc);
      check_eq("st.wrap", 128'(lane_count[63:56]), 128'(8'h01));
      cycle(1'b1, 3'd7, 16'h7777, 8'h00, acc);
      stats_clear = 1'b1;
      cycle(1'b0, 3'd0, '0, 8'h80, acc);
      stats_clear = 1'b0;
      check_eq("st.clrwin", 128'(lane_count[63:56]), 128'(8'h00));
`endif

      // Random traffic; the producer holds its offer until accepted.
      pv  = 1'b0;
      ps  = 3'd0;
      pd  = '0;
      acc = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (!pv || acc) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = 3'($urandom_range(0, 7));
            pd = W'($urandom);
         end
         cycle(pv, ps, pd, 8'($urandom & $urandom), acc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
